leaf_crossbar_scheduler: RTL and testbench

- Arbitration and sequencing controller for a group leaf router's 5-port bidirectional crossbar (GPU plus spines 1-4).
- Arbitrates among the five ingress requesters with round-robin fairness.
- Resolves each winner's egress port from its 6-bit destination address and holds the grant for a whole burst.
- Drives the crossbar's one-hot grant/select and busy/current_grant/direction status lines; enforces burst-length and stall-timeout limits.

---
 rtl/leaf_crossbar_scheduler.sv | 153 +++++++++++++++
 tb/tb_leaf_crossbar_scheduler.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_crossbar_scheduler.sv
// rtl/leaf_crossbar_scheduler.sv - round-robin burst scheduler for a 5-port leaf crossbar
//
// Purpose: picks one of five ingress requesters (GPU, spine1-4) round-robin,
// resolves its egress from the destination address, holds the grant for the
// burst and releases on last beat, burst-length limit or stall timeout.
//
// Ports:
//   clk, reset (async active-low)  clock and reset
//   arb_enable                     permits new grants
//   req_valid[4:0], req_last[4:0]  per-requester beat valid / final beat
//   dest_addr[29:0]                6-bit destination per requester
//   out_ready[4:0]                 per-egress ready
//   grant[4:0], sel_out[4:0]       one-hot ingress grant / egress select
//   xfer                           beat moved this cycle
//   crossbar_busy, current_grant   grant status (current_grant 7 = none)
//   routing_direction              00 idle, 01 up, 10 down, 11 drain
//   timeout_pulse, misroute_pulse  event pulses
module leaf_crossbar_scheduler #(
   parameter logic [3:0] GROUP_ID  = 4'b1000,
   parameter int         MAX_BURST = 8,
   parameter int         TIMEOUT   = 15
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        arb_enable,
   input  logic [4:0]  req_valid,
   input  logic [4:0]  req_last,
   input  logic [29:0] dest_addr,
   input  logic [4:0]  out_ready,
   output logic [4:0]  grant,
   output logic [4:0]  sel_out,
   output logic        xfer,
   output logic        crossbar_busy,
   output logic [2:0]  current_grant,
   output logic [1:0]  routing_direction,
   output logic        timeout_pulse,
   output logic        misroute_pulse
);
   typedef enum logic [1:0] {S_IDLE, S_GRANT, S_RELEASE} state_t;

   localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
   localparam logic [7:0] STALL_LAST = 8'(TIMEOUT - 1);

   state_t     state;
   logic [2:0] ptr;
   logic [7:0] beat_cnt;
   logic [7:0] stall_cnt;
   logic       drain;

   // Round-robin scan from ptr upward, wrapping mod 5.
   logic       found;
   logic [2:0] win;
   logic [3:0] cand;
   always_comb begin
      found = 1'b0;
      win   = 3'd0;
      cand  = 4'd0;
      for (int k = 0; k < 5; k++) begin
         cand = {1'b0, ptr} + 4'(k);
         if (cand >= 4'd5) cand = cand - 4'd5;
         if (!found && req_valid[cand[2:0]]) begin
            found = 1'b1;
            win   = cand[2:0];
         end
      end
   end

   // Egress resolution for the winner; sampled only when the grant is issued.
   logic [5:0] win_addr;
   logic [4:0] win_sel;
   logic [1:0] win_dir;
   logic       win_drain;
   always_comb begin
      win_addr  = dest_addr[6*win +: 6];
      win_sel   = 5'd0;
      win_dir   = 2'b11;
      win_drain = 1'b1;
      if (win_addr[5:2] == GROUP_ID) begin
         win_sel   = 5'b00001;
         win_dir   = 2'b10;
         win_drain = 1'b0;
      end else if (win == 3'd0) begin
         win_sel   = 5'b00010 << win_addr[1:0];
         win_dir   = 2'b01;
         win_drain = 1'b0;
      end
   end

   // A drained burst is consumed regardless of egress readiness.
   logic done;
   assign xfer          = (state == S_GRANT) && (|(req_valid & grant)) &&
                          (drain || (|(out_ready & sel_out)));
   assign timeout_pulse = (state == S_GRANT) && !xfer && (stall_cnt == STALL_LAST);
   assign done          = xfer && ((|(req_last & grant)) || (beat_cnt == BURST_LAST));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state             <= S_IDLE;
         ptr               <= 3'd0;
         beat_cnt          <= 8'd0;
         stall_cnt         <= 8'd0;
         drain             <= 1'b0;
         grant             <= 5'd0;
         sel_out           <= 5'd0;
         crossbar_busy     <= 1'b0;
         current_grant     <= 3'd7;
         routing_direction <= 2'b00;
         misroute_pulse    <= 1'b0;
      end else begin
         case (state)
            // RELEASE is the dead cycle; it arbitrates with the advanced
            // pointer so back-to-back grants are spaced by exactly one cycle.
            S_IDLE, S_RELEASE: begin
               beat_cnt  <= 8'd0;
               stall_cnt <= 8'd0;
               if (arb_enable && found) begin
                  state             <= S_GRANT;
                  grant             <= 5'b00001 << win;
                  sel_out           <= win_sel;
                  routing_direction <= win_dir;
                  drain             <= win_drain;
                  misroute_pulse    <= win_drain;
                  crossbar_busy     <= 1'b1;
                  current_grant     <= win;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_GRANT: begin
               misroute_pulse <= 1'b0;
               if (done || timeout_pulse) begin
                  state             <= S_RELEASE;
                  grant             <= 5'd0;
                  sel_out           <= 5'd0;
                  routing_direction <= 2'b00;
                  crossbar_busy     <= 1'b0;
                  current_grant     <= 3'd7;
                  drain             <= 1'b0;
                  ptr               <= (current_grant == 3'd4) ? 3'd0 : current_grant + 3'd1;
                  beat_cnt          <= 8'd0;
                  stall_cnt         <= 8'd0;
               end else if (xfer) begin
                  beat_cnt  <= beat_cnt + 8'd1;
                  stall_cnt <= 8'd0;
               end else begin
                  stall_cnt <= stall_cnt + 8'd1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_leaf_crossbar_scheduler.sv
// tb/tb_leaf_crossbar_scheduler.sv - scoreboard bench for leaf_crossbar_scheduler
module tb_leaf_crossbar_scheduler;
   logic        clk = 1'b0;
   logic        reset;
   logic        arb_enable;
   logic [4:0]  req_valid;
   logic [4:0]  req_last;
   logic [29:0] dest_addr;
   logic [4:0]  out_ready;
   logic [4:0]  grant;
   logic [4:0]  sel_out;
   logic        xfer;
   logic        crossbar_busy;
   logic [2:0]  current_grant;
   logic [1:0]  routing_direction;
   logic        timeout_pulse;
   logic        misroute_pulse;

   leaf_crossbar_scheduler dut (
      .clk(clk), .reset(reset), .arb_enable(arb_enable),
      .req_valid(req_valid), .req_last(req_last), .dest_addr(dest_addr),
      .out_ready(out_ready), .grant(grant), .sel_out(sel_out), .xfer(xfer),
      .crossbar_busy(crossbar_busy), .current_grant(current_grant),
      .routing_direction(routing_direction), .timeout_pulse(timeout_pulse),
      .misroute_pulse(misroute_pulse)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] g;
      logic [4:0] sel;
      logic [1:0] dir;
      bit         mis;
      int         beats;
      int         len;
      int         tos;
      int         gap;
      bit         abort;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   passed = 0;

   int         beats_left[5];
   logic [5:0] dst[5];
   bit         refill = 1'b0;
   int         xfer_total = 0;
   logic [4:0] xmask;
   logic       seen_to;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   function automatic int onehot_idx(input logic [4:0] v);
      for (int i = 0; i < 5; i++) if (v[i]) return i;
      return 7;
   endfunction

   task automatic expect_grant(input logic [4:0] g, input logic [4:0] s, input logic [1:0] d,
                               input bit m, input int beats, input int len, input int tos,
                               input int gap, input bit abort);
      exp_t e;
      e.g = g; e.sel = s; e.dir = d; e.mis = m; e.beats = beats; e.len = len;
      e.tos = tos; e.gap = gap; e.abort = abort;
      exp_q.push_back(e);
   endtask

   task automatic drive();
      for (int i = 0; i < 5; i++) begin
         req_valid[i] = (beats_left[i] > 0);
         req_last[i]  = (beats_left[i] == 1);
      end
      dest_addr = {dst[4], dst[3], dst[2], dst[1], dst[0]};
   endtask

   task automatic step();
      @(negedge clk);
      xmask   = xfer ? grant : 5'd0;
      seen_to = timeout_pulse;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
         if (xmask[i]) begin
            if (beats_left[i] > 0) beats_left[i]--;
            xfer_total++;
            if (refill && beats_left[i] == 0) beats_left[i] = 1;
         end
      end
      drive();
   endtask

   task automatic wait_done(input string name, input int budget);
      int n = 0;
      while (!(exp_q.size() == 0 && !crossbar_busy &&
               beats_left[0] == 0 && beats_left[1] == 0 && beats_left[2] == 0 &&
               beats_left[3] == 0 && beats_left[4] == 0) && n < budget) begin
         step();
         n++;
      end
      if (n >= budget) chk({name, "_wait_budget"}, 0, 1);
      step();
      step();
   endtask

   // Monitor: pops an expectation at each grant start, checks burst totals at release.
   exp_t cur;
   bit   active = 1'b0;
   int   beats_c, len_c, tos_c, mis_c;
   int   idle_c = 0;

   always @(negedge clk) begin
      if (!reset) begin
         active = 1'b0;
         idle_c = 0;
      end else begin
         if (!active && grant != 5'd0) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_grant", int'(grant), 0);
               cur.abort = 1'b1;
            end else begin
               cur = exp_q.pop_front();
               chk("grant", int'(grant), int'(cur.g));
               chk("sel_out", int'(sel_out), int'(cur.sel));
               chk("direction", int'(routing_direction), int'(cur.dir));
               chk("current_grant", int'(current_grant), onehot_idx(cur.g));
               chk("busy", int'(crossbar_busy), 1);
               chk("misroute_first", int'(misroute_pulse), int'(cur.mis));
               if (cur.gap >= 0) chk("idle_gap", idle_c, cur.gap);
            end
            active = 1'b1;
            beats_c = 0; len_c = 0; tos_c = 0; mis_c = 0;
         end
         if (active && grant == 5'd0) begin
            if (!cur.abort) begin
               chk("beats", beats_c, cur.beats);
               chk("grant_len", len_c, cur.len);
               chk("timeouts", tos_c, cur.tos);
               chk("misroutes", mis_c, int'(cur.mis));
            end
            chk("rel_current_grant", int'(current_grant), 7);
            chk("rel_direction", int'(routing_direction), 0);
            chk("rel_sel", int'(sel_out), 0);
            active = 1'b0;
            idle_c = 0;
         end
         if (active) begin
            len_c++;
            if (xfer) beats_c++;
            if (timeout_pulse) tos_c++;
            if (misroute_pulse) mis_c++;
         end else begin
            idle_c++;
         end
      end
   end

   initial begin
      int n;
      reset = 1'b0;
      arb_enable = 1'b1;
      out_ready = 5'b11111;
      for (int i = 0; i < 5; i++) begin beats_left[i] = 0; dst[i] = 6'b100000; end
      drive();
      #12;
      chk("rst_grant", int'(grant), 0);
      chk("rst_current_grant", int'(current_grant), 7);
      chk("rst_direction", int'(routing_direction), 0);
      chk("rst_busy", int'(crossbar_busy), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      step();

      // GPU non-local to spine2, 3 beats; grant one cycle after request.
      dst[0] = 6'b010001; beats_left[0] = 3; drive();
      expect_grant(5'b00001, 5'b00100, 2'b01, 0, 3, 3, 0, -1, 0);
      step();
      chk("latency_grant", int'(grant), 1);
      wait_done("gpu_up", 30);

      // Spine2 non-local: drained with egress ready held low.
      out_ready = 5'b00000;
      dst[2] = 6'b010011; beats_left[2] = 4; drive();
      expect_grant(5'b00100, 5'b00000, 2'b11, 1, 4, 4, 0, -1, 0);
      wait_done("drain", 30);

      // GPU local loopback stalled by out_ready[0]=0 until timeout.
      out_ready = 5'b11110;
      dst[0] = 6'b100000; beats_left[0] = 3; drive();
      expect_grant(5'b00001, 5'b00001, 2'b10, 0, 0, 15, 1, -1, 0);
      n = 0;
      seen_to = 1'b0;
      while (!seen_to && n < 40) begin step(); n++; end
      if (!seen_to) chk("timeout_seen", 0, 1);
      beats_left[0] = 0; out_ready = 5'b11111; drive();
      wait_done("timeout", 30);

      // Pointer now 1: spine1 wins over GPU, then GPU after one dead cycle.
      dst[0] = 6'b010011; dst[1] = 6'b100010;
      beats_left[0] = 1; beats_left[1] = 1; drive();
      expect_grant(5'b00010, 5'b00001, 2'b10, 0, 1, 1, 0, -1, 0);
      expect_grant(5'b00001, 5'b10000, 2'b01, 0, 1, 1, 0, 1, 0);
      wait_done("pointer", 30);

      // Reset mid-burst while spine1 holds the grant.
      dst[1] = 6'b100000; beats_left[1] = 5; drive();
      expect_grant(5'b00010, 5'b00001, 2'b10, 0, 0, 0, 0, -1, 1);
      step(); step();
      chk("midburst_grant", int'(grant), 2);
      reset = 1'b0;
      #1;
      chk("mid_rst_grant", int'(grant), 0);
      chk("mid_rst_sel", int'(sel_out), 0);
      chk("mid_rst_xfer", int'(xfer), 0);
      chk("mid_rst_busy", int'(crossbar_busy), 0);
      chk("mid_rst_cg", int'(current_grant), 7);
      chk("mid_rst_dir", int'(routing_direction), 0);
      chk("mid_rst_mis", int'(misroute_pulse), 0);
      for (int i = 0; i < 5; i++) beats_left[i] = 0;
      drive();
      step(); step();
      reset = 1'b1;
      step();

      // All five requesting continuously, 1-beat bursts, from pointer 0.
      dst[0] = 6'b010001; dst[1] = 6'b100000; dst[2] = 6'b100000;
      dst[3] = 6'b010011; dst[4] = 6'b100000;
      expect_grant(5'b00001, 5'b00100, 2'b01, 0, 1, 1, 0, -1, 0);
      expect_grant(5'b00010, 5'b00001, 2'b10, 0, 1, 1, 0, 1, 0);
      expect_grant(5'b00100, 5'b00001, 2'b10, 0, 1, 1, 0, 1, 0);
      expect_grant(5'b01000, 5'b00000, 2'b11, 1, 1, 1, 0, 1, 0);
      expect_grant(5'b10000, 5'b00001, 2'b10, 0, 1, 1, 0, 1, 0);
      expect_grant(5'b00001, 5'b00100, 2'b01, 0, 1, 1, 0, 1, 0);
      xfer_total = 0;
      refill = 1'b1;
      for (int i = 0; i < 5; i++) beats_left[i] = 1;
      drive();
      n = 0;
      while (xfer_total < 6 && n < 60) begin step(); n++; end
      if (xfer_total < 6) chk("rr_budget", xfer_total, 6);
      refill = 1'b0;
      for (int i = 0; i < 5; i++) beats_left[i] = 0;
      drive();
      wait_done("round_robin", 30);

      // Spine4 10-beat burst split at MAX_BURST=8.
      dst[4] = 6'b100000; beats_left[4] = 10; drive();
      expect_grant(5'b10000, 5'b00001, 2'b10, 0, 8, 8, 0, -1, 0);
      expect_grant(5'b10000, 5'b00001, 2'b10, 0, 2, 2, 0, 1, 0);
      wait_done("max_burst", 40);

      // arb_enable low blocks a new grant; raising it releases the request.
      arb_enable = 1'b0;
      dst[3] = 6'b100000; beats_left[3] = 1; drive();
      for (int i = 0; i < 4; i++) step();
      chk("disabled_grant", int'(grant), 0);
      expect_grant(5'b01000, 5'b00001, 2'b10, 0, 1, 1, 0, -1, 0);
      arb_enable = 1'b1;
      wait_done("enable", 30);

      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
